// File: rtl/pattern_serializer_if.sv
// Start-request bundle for pattern_serializer: pattern, length and repeat count are qualified by start_valid.
// The slave raises start_ready only while idle, so a request is accepted on a single valid&&ready cycle.
interface pattern_serializer_if #(
    parameter int width       = 10,
    parameter int len_width   = 4,
    parameter int count_width = 4
);
    logic                   start_valid;
    logic                   start_ready;
    logic [width-1:0]       pattern;
    logic [len_width-1:0]   length;
    logic [count_width-1:0] repeat_count;

    modport master (
        output start_valid,
        output pattern,
        output length,
        output repeat_count,
        input  start_ready
    );

    modport slave (
        input  start_valid,
        input  pattern,
        input  length,
        input  repeat_count,
        output start_ready
    );
endinterface

// File: rtl/pattern_serializer.sv
// Shifts a latched pattern out LSB first, one bit per enable strobe, with optional repeats separated by idle gap bits.
// First bit appears the cycle after acceptance; requests are accepted only in IDLE and dropped (not queued) otherwise.
module pattern_serializer #(
    parameter int width       = 10,
    parameter int len_width   = 4,
    parameter int count_width = 4,
    parameter int gap_bits    = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    pattern_serializer_if.slave  start,
    output logic                 out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done
);
    localparam int index_w = (width > 1) ? $clog2(width) : 1;
    localparam int len_w   = $clog2(width + 1);
    localparam int gap_w   = (gap_bits > 0) ? $clog2(gap_bits + 1) : 1;
    localparam int reps_w  = count_width + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [width-1:0]    pat_q, pat_d;
    logic [len_w-1:0]    len_q, len_d;
    logic [reps_w-1:0]   reps_q, reps_d;
    logic [index_w-1:0]  index_q, index_d;
    logic [gap_w-1:0]    gap_q, gap_d;

    logic [len_w-1:0]    eff_len;
    logic [reps_w-1:0]   eff_reps;
    logic                last_bit;
    logic                gap_last;

    // Zero or oversize lengths fall back to the full pattern width.
    always_comb begin
        eff_len = len_w'(width);
        if (start.length != '0 && int'(start.length) <= width) begin
            eff_len = len_w'(start.length);
        end
    end

    assign eff_reps = (start.repeat_count == '0) ? reps_w'(1) : reps_w'(start.repeat_count);
    assign last_bit = (int'(index_q) + 1) >= int'(len_q);
    assign gap_last = (int'(gap_q) + 1) >= gap_bits;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            reps_q  <= '0;
            index_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            reps_q  <= reps_d;
            index_q <= index_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        reps_d  = reps_q;
        index_d = index_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                // enable is deliberately not looked at here: a strobe in the acceptance cycle is ignored.
                if (start.start_valid) begin
                    pat_d   = start.pattern;
                    len_d   = eff_len;
                    reps_d  = eff_reps;
                    index_d = '0;
                    gap_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (enable) begin
                    if (!last_bit) begin
                        index_d = index_q + 1'b1;
                    end else begin
                        reps_d  = reps_q - 1'b1;
                        index_d = '0;
                        if (reps_q == reps_w'(1)) begin
                            state_d = DONE;
                        end else if (gap_bits > 0) begin
                            gap_d   = '0;
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (enable) begin
                    if (gap_last) begin
                        gap_d   = '0;
                        index_d = '0;
                        state_d = SEND;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so start_valid never reaches them combinationally.
    assign start.start_ready = (state_q == IDLE);
    assign out_valid         = (state_q == SEND);
    assign out               = (state_q == SEND) && pat_q[index_q];
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);
endmodule

// File: tb/tb_pattern_serializer.sv
module tb_pattern_serializer;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic enable  = 1'b0;
    int   en_period = 0;
    int   en_cnt    = 0;
    int   checks = 0;
    int   errors = 0;

    always #10 clock = ~clock;

    // Free-running strobe: every cycle when en_period is 0, else one cycle in en_period.
    always @(posedge clock) begin
        if (en_period == 0) begin
            enable <= 1'b1;
            en_cnt <= 0;
        end else begin
            en_cnt <= (en_cnt >= en_period - 1) ? 0 : en_cnt + 1;
            enable <= (en_cnt == en_period - 1);
        end
    end

    pattern_serializer_if #(.width(10), .len_width(4), .count_width(4)) a_if ();
    pattern_serializer_if #(.width(10), .len_width(4), .count_width(4)) b_if ();
    logic a_out, a_vld, a_busy, a_done;
    logic b_out, b_vld, b_busy, b_done;

    pattern_serializer #(.width(10), .len_width(4), .count_width(4), .gap_bits(2)) dut_a (
        .clock(clock), .reset_n(reset_n), .enable(enable), .start(a_if),
        .out(a_out), .out_valid(a_vld), .busy(a_busy), .done(a_done)
    );

    pattern_serializer #(.width(10), .len_width(4), .count_width(4), .gap_bits(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .enable(enable), .start(b_if),
        .out(b_out), .out_valid(b_vld), .busy(b_busy), .done(b_done)
    );

    typedef struct {
        logic [9:0]   pattern;
        logic [3:0]   length;
        logic [3:0]   reps;
        logic [127:0] exp_out;
        logic [127:0] exp_vld;
        int           exp_n;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_a(input int v, input int inj_k, input int rst_k);
        logic [127:0] o;
        logic [127:0] vl;
        int done_k;
        bit side_ok;
        o = '0; vl = '0; done_k = -1; side_ok = 1'b1;
        @(negedge clock);
        chk($sformatf("v%0d_ready_before", v), a_if.start_ready, 1);
        a_if.start_valid  = 1'b1;
        a_if.pattern      = tbl[v].pattern;
        a_if.length       = tbl[v].length;
        a_if.repeat_count = tbl[v].reps;
        @(posedge clock);
        #1;
        a_if.start_valid  = 1'b0;
        a_if.pattern      = ~tbl[v].pattern;
        a_if.length       = 4'd1;
        a_if.repeat_count = 4'd7;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            if (a_done) begin
                done_k = k;
                break;
            end
            o[k-1]  = a_out;
            vl[k-1] = a_vld;
            if (!a_busy || a_if.start_ready) side_ok = 1'b0;
            if (k == rst_k) begin
                reset_n = 1'b0;
                #1;
                chk($sformatf("v%0d_rst_at_%0d", v, k),
                    {a_out, a_vld, a_busy, a_done, a_if.start_ready}, 5'b00001);
                @(posedge clock);
                @(negedge clock);
                reset_n = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clock);
                    if (a_done || a_busy || !a_if.start_ready) side_ok = 1'b0;
                end
                chk($sformatf("v%0d_rst_quiet", v), side_ok, 1);
                return;
            end
            if (k == inj_k) begin
                a_if.start_valid  = 1'b1;
                a_if.pattern      = 10'h3FF;
                a_if.length       = 4'd1;
                a_if.repeat_count = 4'd1;
            end else if (k == inj_k + 1) begin
                a_if.start_valid = 1'b0;
            end
        end
        a_if.start_valid = 1'b0;
        chk($sformatf("v%0d_out_seq", v), o, tbl[v].exp_out);
        chk($sformatf("v%0d_vld_seq", v), vl, tbl[v].exp_vld);
        chk($sformatf("v%0d_done_cycle", v), done_k, tbl[v].exp_n);
        chk($sformatf("v%0d_busy_notready", v), side_ok, 1);
        @(negedge clock);
        chk($sformatf("v%0d_after_done", v), {a_done, a_if.start_ready, a_busy}, 3'b010);
    endtask

    task automatic run_b(input logic [3:0] reps, input logic [127:0] exp_out,
                         input logic [127:0] exp_vld, input int exp_n);
        logic [127:0] o;
        logic [127:0] vl;
        int done_k;
        o = '0; vl = '0; done_k = -1;
        @(negedge clock);
        b_if.start_valid  = 1'b1;
        b_if.pattern      = 10'b10;
        b_if.length       = 4'd2;
        b_if.repeat_count = reps;
        @(posedge clock);
        #1;
        b_if.start_valid = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            if (b_done) begin
                done_k = k;
                break;
            end
            o[k-1]  = b_out;
            vl[k-1] = b_vld;
        end
        chk($sformatf("nogap_r%0d_out_seq", reps), o, exp_out);
        chk($sformatf("nogap_r%0d_vld_seq", reps), vl, exp_vld);
        chk($sformatf("nogap_r%0d_done_cycle", reps), done_k, exp_n);
        @(negedge clock);
        chk($sformatf("nogap_r%0d_after_done", reps), {b_done, b_if.start_ready}, 2'b01);
    endtask

    initial begin
        logic [127:0] seq15;
        int strobes;
        int last_en;
        int done_k;
        bit side_ok;

        seq15 = '0;
        for (int k = 0; k < 43; k++) seq15[k] = (k % 3 == 0);
        tbl[0] = '{10'b10,   4'd2,  4'd1,  128'b10,            128'b11,            3};
        tbl[1] = '{10'h2AA,  4'd0,  4'd1,  128'h2AA,           128'h3FF,           11};
        tbl[2] = '{10'h2AA,  4'd12, 4'd1,  128'h2AA,           128'h3FF,           11};
        tbl[3] = '{10'b101,  4'd3,  4'd3,  128'b1010010100101, 128'b1110011100111, 14};
        tbl[4] = '{10'b1,    4'd1,  4'd2,  128'b1001,          128'b1001,          5};
        tbl[5] = '{10'b1,    4'd1,  4'd15, seq15,              seq15,              44};

        a_if.start_valid = 1'b0; a_if.pattern = '0; a_if.length = '0; a_if.repeat_count = '0;
        b_if.start_valid = 1'b0; b_if.pattern = '0; b_if.length = '0; b_if.repeat_count = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_state_a", {a_out, a_vld, a_busy, a_done, a_if.start_ready}, 5'b00001);
        chk("reset_state_b", {b_out, b_vld, b_busy, b_done, b_if.start_ready}, 5'b00001);
        reset_n = 1'b1;

        // Slow strobe: first bit may be short, done follows the second strobe by one cycle.
        en_period = 4;
        repeat (5) @(negedge clock);
        a_if.start_valid = 1'b1; a_if.pattern = 10'b10; a_if.length = 4'd2; a_if.repeat_count = 4'd1;
        @(posedge clock);
        #1;
        a_if.start_valid = 1'b0;
        strobes = 0; last_en = -10; done_k = -1; side_ok = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (a_done) begin
                done_k = k;
                break;
            end
            if (a_out !== (strobes > 0) || a_vld !== 1'b1) side_ok = 1'b0;
            if (enable) begin
                strobes++;
                last_en = k;
            end
        end
        chk("slow_strobes_used", strobes, 2);
        chk("slow_done_after_strobe", done_k, last_en + 1);
        chk("slow_bits", side_ok, 1);

        en_period = 0;
        repeat (3) @(negedge clock);

        for (int v = 0; v < 6; v++) run_a(v, -5, 0);
        run_a(3, 3, 0);
        run_a(0, -5, 0);
        run_a(3, -5, 2);
        run_a(3, -5, 4);
        run_a(1, -5, 0);

        run_b(4'd0, 128'b10, 128'b11, 3);
        run_b(4'd2, 128'b1010, 128'b1111, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Transmit-side counterpart of the serial pattern detectors: accepts a parallel bit pattern via a valid/ready handshake and shifts it out LSB first, one bit per timer strobe, optionally repeating it with idle gap bits between repetitions. Sits between control logic (keys/switches) and the serial input of the Moore/Mealy pattern detectors, sharing the same `clock` and timer `enable` strobe.

## Interface
- `width`, 10, maximum pattern length in bits
- `len_width`, 4, width of `length` input
- `count_width`, 4, width of `repeat_count` input
- `gap_bits`, 2, idle (0) bits inserted between repetitions; 0 allowed

- `clock`  in  1  system clock, 50 MHz
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  bit-period strobe, one clock cycle wide
- `start_valid`  in  1  request to transmit
- `start_ready`  out  1  high when a request can be accepted
- `pattern`  in  width  bits to send, bit 0 first
- `length`  in  len_width  bits per repetition; 0 or >width means width
- `repeat_count`  in  count_width  repetitions; 0 means 1
- `out`  out  1  serial data
- `out_valid`  out  1  high while `out` carries a pattern bit
- `busy`  out  1  high from acceptance until `done`
- `done`  out  1  one-cycle pulse at end of transmission

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE: `start_ready`=1, `out`=0, `out_valid`=0, `busy`=0. `start_valid`&&`start_ready` accepts: latches `pattern`, effective length L, effective repeat R; bit index=0, reps left=R; goes to SEND.
- SEND: `out`=latched pattern[index], `out_valid`=1. On `enable`: if index<L-1, index+1; else reps left-1; if reps left now 0 → DONE; else if `gap_bits`>0 → GAP (gap counter=0); else index=0, stay SEND.
- GAP: `out`=0, `out_valid`=0. On `enable`: gap counter+1; when it reaches `gap_bits` → SEND, index=0.
- DONE: `done`=1, `out`=0, `out_valid`=0, `busy`=1 for exactly one cycle, then IDLE.
- `start_ready`=1 only in IDLE; `start_valid` in other states is ignored, not queued. Inputs `pattern`/`length`/`repeat_count` sampled only at acceptance.
- Counters sized: index ceil(log2(width)) bits min 1, gap counter ceil(log2(gap_bits+1)) min 1, reps count_width+1 bits (no wrap at R=2^count_width-1).

## Timing
- Reset (async, any state): state IDLE, `out`=0, `out_valid`=0, `busy`=0, `done`=0, `start_ready`=1; all counters 0.
- All outputs registered or decoded from state/counters only; no combinational path from `start_valid` to outputs.
- Acceptance cycle N: outputs change at cycle N+1 (SEND, first bit on `out`). An `enable` coincident with cycle N is ignored.
- First bit lasts from N+1 until the first `enable` after N (may be shorter than a full period; strobe is free-running). Each later bit/gap bit lasts exactly one strobe period.
- Total strobes consumed: R*L + (R-1)*gap_bits; `done` asserted the cycle after the final strobe, `start_ready` returns one cycle later.
- `enable` held high continuously: one bit per clock (used in simulation).

## Test plan
- `pattern`=10'b0000000010, `length`=2, `repeat_count`=1, strobe every 4 cycles → `out` 0 then 1, `out_valid` high for 2 bit periods, `done` one cycle after 2nd strobe; Moore detector fed by `out` asserts y.
- `length`=0, `pattern`=10'h2AA → 10 bits 0,1,0,1,…,1 sent; `length`=12 gives the same.
- `pattern`=3'b101 (`length`=3), `repeat_count`=3, `gap_bits`=2, `enable` constant → `out`=1,0,1,0,0,1,0,1,0,0,1,0,1, `out_valid` low only on the 4 gap bits; `done` at cycle 14 after acceptance.
- Pulse `start_valid` while `busy` with different pattern → ignored, original transmission completes unchanged; a new request after `start_ready` returns is accepted.
- Assert `reset_n` low mid-SEND and mid-GAP → all outputs 0 and `start_ready`=1 immediately, no `done` pulse; subsequent request transmits normally.
- `gap_bits`=0 build, `length`=2, `repeat_count`=0 (→1) then `repeat_count`=2 → 2 bits then 4 back-to-back bits with no idle gap.
